// File: rtl/cam_capture.sv
// cam_capture: DVP-style camera byte capture into 32-bit words
// Frame/line sequencing FSM feeding a 4-deep FWFT output FIFO.
module cam_capture #(
  parameter int FRAME_WIDTH  = 4,
  parameter int FRAME_HEIGHT = 4
) (
  input  logic        cam_pclk,
  input  logic        cam_rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        cfg_enable,
  input  logic        clr_status,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        status_ovf,
  output logic        status_err
);

  localparam int BPL = 2 * FRAME_WIDTH;
  localparam int BW  = $clog2(BPL + 1);
  localparam int LW  = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [BW-1:0] BPL_C     = BW'(BPL);
  localparam logic [BW-1:0] BPL_M1    = BW'(BPL - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(FRAME_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_VSYNC,
    S_FRAME
  } state_t;

  state_t state_q, state_d;

  logic          vsync_q;
  logic          href_q;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [23:0]   lanes_q, lanes_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          ovf_q;
  logic          err_q;

  logic          vs_rise;
  logic          vs_fall;
  logic          href_fall;
  logic          err_set;
  logic          push;
  logic [32:0]   push_word;

  logic [32:0]   mem_q [4];
  logic [1:0]    wr_q;
  logic [1:0]    rd_q;
  logic [2:0]    cnt_q;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr_en;
  logic          drop;

  assign vs_rise   = cam_vsync & ~vsync_q;
  assign vs_fall   = ~cam_vsync & vsync_q;
  assign href_fall = ~cam_href & href_q;

  // Registered copies of the sync inputs for edge detection
  always_ff @(posedge cam_pclk or posedge cam_rst) begin
    if (cam_rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
    end
  end

  // Sequencer state and capture counters
  always_ff @(posedge cam_pclk or posedge cam_rst) begin
    if (cam_rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      line_cnt_q   <= '0;
      lanes_q      <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      line_cnt_q   <= line_cnt_d;
      lanes_q      <= lanes_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state, byte packing, line/frame bookkeeping
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    line_cnt_d   = line_cnt_q;
    lanes_d      = lanes_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    err_set      = 1'b0;
    push         = 1'b0;
    push_word    = {1'b0, cam_data, lanes_q};
    unique case (state_q)
      S_IDLE: begin
        if (cfg_enable) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (!cfg_enable) state_d = S_IDLE;
        else if (vs_rise) state_d = S_VSYNC;
      end
      S_VSYNC: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else if (vs_fall) begin
          state_d    = S_FRAME;
          byte_cnt_d = '0;
          line_cnt_d = '0;
        end
      end
      S_FRAME: begin
        if (vs_rise) begin
          // early vsync: abandon frame, partial word is lost
          err_set    = 1'b1;
          state_d    = S_VSYNC;
          byte_cnt_d = '0;
          line_cnt_d = '0;
        end else if (cam_href) begin
          if (byte_cnt_q == BPL_C) begin
            err_set = 1'b1;
          end else begin
            unique case (byte_cnt_q[1:0])
              2'd0: lanes_d[7:0]   = cam_data;
              2'd1: lanes_d[15:8]  = cam_data;
              2'd2: lanes_d[23:16] = cam_data;
              2'd3: begin
                push          = 1'b1;
                push_word[32] = (line_cnt_q == LAST_LINE) &&
                                (byte_cnt_q == BPL_M1);
              end
            endcase
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end else if (href_fall) begin
          if (byte_cnt_q != BPL_C) err_set = 1'b1;
          byte_cnt_d = '0;
          if (line_cnt_q == LAST_LINE) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            line_cnt_d   = '0;
            state_d      = cfg_enable ? S_SYNC : S_IDLE;
          end else begin
            line_cnt_d = line_cnt_q + LW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full  = (cnt_q == 3'd4);
  assign empty = (cnt_q == 3'd0);
  assign pop   = ~empty & out_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // FIFO storage; a full FIFO still accepts when a pop frees the slot
  always_ff @(posedge cam_pclk or posedge cam_rst) begin
    if (cam_rst) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_q] <= push_word;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge cam_pclk or posedge cam_rst) begin
    if (cam_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 2'd1;
      if (pop)   rd_q <= rd_q + 2'd1;
      if (wr_en && !pop)      cnt_q <= cnt_q + 3'd1;
      else if (!wr_en && pop) cnt_q <= cnt_q - 3'd1;
    end
  end

  // Sticky status; a set event beats a clear in the same cycle
  always_ff @(posedge cam_pclk or posedge cam_rst) begin
    if (cam_rst) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~clr_status) | drop;
      err_q <= (err_q & ~clr_status) | err_set;
    end
  end

  assign out_valid  = ~empty;
  assign out_data   = empty ? 32'd0 : mem_q[rd_q][31:0];
  assign out_last   = empty ? 1'b0 : mem_q[rd_q][32];
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign status_ovf = ovf_q;
  assign status_err = err_q;

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: directed frames against a byte-stream word model
// Model packs driven bytes into words and tracks a 4-entry queue.
module tb_cam_capture;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int BPL = 2 * W;

  logic        cam_pclk = 1'b0;
  logic        cam_rst  = 1'b1;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic        cfg_enable = 1'b0;
  logic        clr_status = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        status_ovf;
  logic        status_err;

  always #5 cam_pclk = ~cam_pclk;

  cam_capture #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .cam_pclk  (cam_pclk),
    .cam_rst   (cam_rst),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .cfg_enable(cfg_enable),
    .clr_status(clr_status),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt),
    .status_ovf(status_ovf),
    .status_err(status_err)
  );

  int tests = 0;
  int fails = 0;

  logic [32:0] mq[$];
  bit          m_done = 0;
  bit          m_ovf = 0;
  bit          m_err = 0;
  logic [15:0] m_frames = 0;
  int          bidx = 0;

  logic [31:0] log_w[$];
  bit          log_l[$];
  int          done_seen = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  always @(negedge cam_pclk) begin
    chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("out_data", {32'd0, out_data}, {32'd0, mq[0][31:0]});
      chk("out_last", {63'd0, out_last}, {63'd0, mq[0][32]});
      if (out_ready) begin
        log_w.push_back(out_data);
        log_l.push_back(out_last);
        void'(mq.pop_front());
      end
    end
    chk("frame_done", {63'd0, frame_done}, {63'd0, m_done});
    chk("frame_cnt", {48'd0, frame_cnt}, {48'd0, m_frames});
    chk("status_ovf", {63'd0, status_ovf}, {63'd0, m_ovf});
    chk("status_err", {63'd0, status_err}, {63'd0, m_err});
    if (cam_rst) begin
      chk("rst_data", {32'd0, out_data}, 64'd0);
      chk("rst_last", {63'd0, out_last}, 64'd0);
    end
    if (frame_done) done_seen++;
  end

  task automatic mpush(input logic [32:0] wd);
    if (mq.size() < 4) mq.push_back(wd);
    else m_ovf = 1;
  endtask

  task automatic step();
    @(posedge cam_pclk);
    m_done = 0;
    if (clr_status && !cam_rst) begin
      m_err = 0;
      m_ovf = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      #1;
    end
  endtask

  task automatic vsync_pulse(input bit early);
    cam_vsync = 1'b1;
    if (early) clr_status = 1'b1;
    step();
    if (early) m_err = 1;
    #1;
    clr_status = 1'b0;
    step();
    #1;
    cam_vsync = 1'b0;
    step();
    #1;
    step();
    #1;
  endtask

  task automatic line(input int n, input bit cap, input bit lastl,
                      input int off_k);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) begin
      if (k == off_k) cfg_enable = 1'b0;
      cam_href = 1'b1;
      cam_data = 8'(bidx);
      step();
      if (cap) begin
        if (k < BPL) begin
          w[8*(k%4) +: 8] = cam_data;
          if (k % 4 == 3) mpush({(lastl && k == BPL - 1), w});
        end else begin
          m_err = 1;
        end
      end
      #1;
      bidx++;
    end
    cam_href = 1'b0;
    step();
    if (cap) begin
      if (n != BPL) m_err = 1;
      if (lastl) begin
        m_done = 1;
        m_frames++;
      end
    end
    #1;
    step();
    #1;
  endtask

  task automatic frame(input bit cap);
    bidx = 0;
    vsync_pulse(0);
    for (int l = 0; l < H; l++) line(BPL, cap, l == H - 1, -1);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    step();
    #1;
    clr_status = 1'b0;
  endtask

  int d0;

  initial begin
    cfg_enable = 1'b1;
    out_ready  = 1'b1;
    idle(3);
    cam_rst = 1'b0;
    idle(3);

    // one clean frame
    log_w.delete();
    log_l.delete();
    frame(1);
    idle(3);
    chk("s1_words", 64'(log_w.size()), 64'd8);
    if (log_w.size() == 8) begin
      chk("s1_w0", {32'd0, log_w[0]}, 64'h03020100);
      chk("s1_w1", {32'd0, log_w[1]}, 64'h07060504);
      chk("s1_w7", {32'd0, log_w[7]}, 64'h1F1E1D1C);
      chk("s1_last7", {63'd0, log_l[7]}, 64'd1);
      chk("s1_last6", {63'd0, log_l[6]}, 64'd0);
    end
    chk("s1_done", 64'(done_seen), 64'd1);
    chk("s1_fcnt", {48'd0, frame_cnt}, 64'd1);
    chk("s1_err", {63'd0, status_err}, 64'd0);

    // backpressure for a whole frame
    log_w.delete();
    log_l.delete();
    out_ready = 1'b0;
    frame(1);
    idle(2);
    chk("s2_ovf", {63'd0, status_ovf}, 64'd1);
    chk("s2_hold", {32'd0, out_data}, 64'h03020100);
    out_ready = 1'b1;
    idle(6);
    chk("s2_words", 64'(log_w.size()), 64'd4);
    if (log_w.size() == 4) chk("s2_w3", {32'd0, log_w[3]}, 64'h0F0E0D0C);
    chk("s2_empty", {63'd0, out_valid}, 64'd0);
    pulse_clr();
    idle(2);

    // short line 1 (6 bytes)
    log_w.delete();
    log_l.delete();
    d0 = done_seen;
    bidx = 0;
    vsync_pulse(0);
    line(BPL, 1, 0, -1);
    line(6, 1, 0, -1);
    line(BPL, 1, 0, -1);
    line(BPL, 1, 1, -1);
    idle(3);
    chk("s3_words", 64'(log_w.size()), 64'd7);
    if (log_w.size() == 7) chk("s3_w2", {32'd0, log_w[2]}, 64'h0B0A0908);
    chk("s3_done", 64'(done_seen - d0), 64'd1);
    chk("s3_err", {63'd0, status_err}, 64'd1);

    // early vsync after two lines, clear colliding with the set
    log_w.delete();
    log_l.delete();
    d0 = done_seen;
    bidx = 0;
    vsync_pulse(0);
    line(BPL, 1, 0, -1);
    line(BPL, 1, 0, -1);
    chk("s4_fcnt_pre", {48'd0, frame_cnt}, 64'd3);
    bidx = 0;
    vsync_pulse(1);
    chk("s4_err", {63'd0, status_err}, 64'd1);
    chk("s4_nodone", 64'(done_seen - d0), 64'd0);
    chk("s4_words_ab", 64'(log_w.size()), 64'd4);
    for (int l = 0; l < H; l++) line(BPL, 1, l == H - 1, -1);
    idle(3);
    chk("s4_fcnt", {48'd0, frame_cnt}, 64'd4);
    chk("s4_words", 64'(log_w.size()), 64'd12);
    if (log_w.size() == 12) chk("s4_w4", {32'd0, log_w[4]}, 64'h03020100);
    pulse_clr();
    idle(2);

    // reset in the middle of line 2
    bidx = 0;
    vsync_pulse(0);
    line(BPL, 1, 0, -1);
    line(BPL, 1, 0, -1);
    for (int k = 0; k < 3; k++) begin
      cam_href = 1'b1;
      cam_data = 8'(bidx);
      step();
      #1;
      bidx++;
    end
    cam_rst  = 1'b1;
    cam_href = 1'b0;
    mq.delete();
    m_frames = 0;
    m_err    = 0;
    m_ovf    = 0;
    m_done   = 0;
    idle(3);
    cam_rst = 1'b0;
    log_w.delete();
    log_l.delete();
    idle(3);
    frame(1);
    idle(3);
    chk("s5_fcnt", {48'd0, frame_cnt}, 64'd1);
    chk("s5_words", 64'(log_w.size()), 64'd8);

    // enable dropped during line 1
    log_w.delete();
    log_l.delete();
    d0 = done_seen;
    bidx = 0;
    vsync_pulse(0);
    line(BPL, 1, 0, -1);
    line(BPL, 1, 0, 3);
    line(BPL, 1, 0, -1);
    line(BPL, 1, 1, -1);
    idle(2);
    vsync_pulse(0);
    for (int l = 0; l < H; l++) line(BPL, 0, 0, -1);
    idle(3);
    chk("s6_done", 64'(done_seen - d0), 64'd1);
    chk("s6_words", 64'(log_w.size()), 64'd8);
    chk("s6_fcnt", {48'd0, frame_cnt}, 64'd2);
    chk("s6_idle", {63'd0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
